uart_rx_fifo: RTL and testbench

- 8N1 UART receiver with a first-word-fall-through byte FIFO, directly upstream of the memory-mapped I/O decoder.
- Replaces the single-byte receive path, so that bursts arriving between software polls of the status register (0x200) are not lost.
- The decoder reads the head byte at 0x202 and issues a one-cycle pop. Overrun and framing errors are reported as sticky flags.

---
 rtl/uart_pkg.sv | 14 +
 rtl/byte_fifo.sv | 73 +++++++
 rtl/uart_rx_fifo.sv | 153 +++++++++++++++
 tb/tb_uart_rx_fifo.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the 8N1 receive path feeding the I/O decoder.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAITHIGH
  } rx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/byte_fifo.sv
// First-word-fall-through byte FIFO; the head byte is visible combinationally.
module byte_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [7:0]            wdata,
  input  logic                  pop,
  output logic [7:0]            rdata,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  dropped
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_DEPTH = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_DEPTH);

  // A pop frees the slot the same cycle, so a full FIFO still accepts a push alongside it.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dropped = push && !do_push;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared on reset so the head byte reads 8'h00 until the first push.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver buffering bytes in a FWFT FIFO, with sticky overrun/framing flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  uartRxPin,
  input  logic                  pop,
  input  logic                  clearErr,
  output logic [7:0]            rdata,
  output logic                  rxReady,
  output logic [DEPTH_LOG2:0]   fifoCount,
  output logic                  overrun,
  output logic                  frameErr
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  logic            sync1_q, rx_s_q;
  rx_state_t       state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            push_byte, frame_set;
  logic            fifo_empty, fifo_full, fifo_dropped;
  logic            overrun_q, frame_err_q;

  // The line is asynchronous; only the second flop is ever looked at.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= uartRxPin;
      rx_s_q  <= sync1_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push_byte = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          baud_d  = '0;
        end
      end
      START: begin
        // A start bit that is already high again at mid-bit was only a glitch.
        if (baud_q == BAUD_HALF) begin
          if (!rx_s_q) begin
            state_d   = DATA;
            baud_d    = '0;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      DATA: begin
        if (baud_q == BAUD_LAST) begin
          shift_d[bit_idx_q] = rx_s_q;
          baud_d             = '0;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (rx_s_q) begin
            push_byte = 1'b1;
            state_d   = IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = WAITHIGH;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      WAITHIGH: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  byte_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push_byte),
    .wdata   (shift_q),
    .pop     (pop),
    .rdata   (rdata),
    .count   (fifoCount),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .dropped (fifo_dropped)
  );

  // A new error event in the same cycle as clearErr must not be lost.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (fifo_dropped)  overrun_q <= 1'b1;
      else if (clearErr) overrun_q <= 1'b0;
      if (frame_set)     frame_err_q <= 1'b1;
      else if (clearErr) frame_err_q <= 1'b0;
    end
  end

  assign rxReady  = !fifo_empty;
  assign overrun  = overrun_q;
  assign frameErr = frame_err_q;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo at 8 clocks per bit.
module tb_uart_rx_fifo;

  localparam int BIT   = 8;
  localparam int DL2   = 4;
  localparam int DEPTH = 1 << DL2;

  logic         clock = 1'b0;
  logic         reset;
  logic         uartRxPin;
  logic         pop;
  logic         clearErr;
  logic [7:0]   rdata;
  logic         rxReady;
  logic [DL2:0] fifoCount;
  logic         overrun;
  logic         frameErr;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [7:0]   sb_q[$];
  logic         exp_ovr = 1'b0;

  always #5 clock = ~clock;

  uart_rx_fifo #(
    .CLKS_PER_BIT(BIT),
    .DEPTH_LOG2  (DL2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .uartRxPin (uartRxPin),
    .pop       (pop),
    .clearErr  (clearErr),
    .rdata     (rdata),
    .rxReady   (rxReady),
    .fifoCount (fifoCount),
    .overrun   (overrun),
    .frameErr  (frameErr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  // mode 0: plain frame; 1: check push latency; 2: pop in the push cycle.
  task automatic send_frame(input logic [7:0] b, input logic stop_val,
                            input int stop_bits, input int mode);
    logic [7:0] exp;
    uartRxPin = 1'b0;
    repeat (BIT) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      uartRxPin = b[i];
      repeat (BIT) @(negedge clock);
    end
    uartRxPin = stop_val;
    if (!stop_val) begin
      repeat (BIT * stop_bits) @(negedge clock);
      uartRxPin = 1'b1;
    end else if (mode == 0) begin
      if (sb_q.size() < DEPTH) sb_q.push_back(b);
      else                     exp_ovr = 1'b1;
      repeat (BIT) @(negedge clock);
    end else begin
      repeat (BIT - 2) @(negedge clock);
      if (mode == 1) begin
        check("ready_before_push", 32'(rxReady), 32'(sb_q.size() != 0));
        sb_q.push_back(b);
        @(negedge clock);
        check("ready_after_push", 32'(rxReady), 1);
        check("rdata_after_push", 32'(rdata), 32'(sb_q[0]));
      end else begin
        exp = sb_q.pop_front();
        check("full_head", 32'(rdata), 32'(exp));
        sb_q.push_back(b);
        pop = 1'b1;
        @(negedge clock);
        pop = 1'b0;
        check("full_pushpop_cnt", 32'(fifoCount), DEPTH);
        check("full_pushpop_ovr", 32'(overrun), 0);
      end
      @(negedge clock);
    end
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] exp;
    check({tag, "_ready"}, 32'(rxReady), 1);
    if (sb_q.size() != 0) begin
      exp = sb_q.pop_front();
      check({tag, "_rdata"}, 32'(rdata), 32'(exp));
    end
    pop = 1'b1;
    @(negedge clock);
    pop = 1'b0;
  endtask

  task automatic pulse_clear();
    clearErr = 1'b1;
    @(negedge clock);
    clearErr = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rxReady"},   32'(rxReady),   0);
    check({tag, "_fifoCount"}, 32'(fifoCount), 0);
    check({tag, "_overrun"},   32'(overrun),   0);
    check({tag, "_frameErr"},  32'(frameErr),  0);
    check({tag, "_rdata"},     32'(rdata),     0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    uartRxPin = 1'b1;
    pop       = 1'b0;
    clearErr  = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_state("reset");
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Single byte with exact push latency.
    send_frame(8'hA5, 1'b1, 1, 1);
    check("single_cnt", 32'(fifoCount), 1);
    pop_check("single_pop");
    check("single_empty", 32'(rxReady), 0);
    check("single_cnt0", 32'(fifoCount), 0);

    // Back-to-back burst overflowing the FIFO.
    for (int i = 0; i < 20; i++) send_frame(8'(i), 1'b1, 1, 0);
    check("burst_cnt", 32'(fifoCount), 32'(sb_q.size()));
    check("burst_ovr", 32'(overrun), 32'(exp_ovr));
    for (int i = 0; i < DEPTH; i++) pop_check("burst_pop");
    check("burst_empty", 32'(rxReady), 0);
    pulse_clear();
    exp_ovr = 1'b0;
    check("burst_ovr_clr", 32'(overrun), 0);

    // Framing error with stop bit held low for three bit times.
    send_frame(8'h3C, 1'b0, 3, 0);
    repeat (4 * BIT) @(negedge clock);
    check("frame_cnt", 32'(fifoCount), 0);
    check("frame_err", 32'(frameErr), 1);
    check("frame_ovr", 32'(overrun), 0);
    send_frame(8'h55, 1'b1, 1, 0);
    check("frame_next_cnt", 32'(fifoCount), 1);
    pop_check("frame_next_pop");
    pulse_clear();
    check("frame_err_clr", 32'(frameErr), 0);

    // Two-cycle glitch is rejected.
    uartRxPin = 1'b0;
    repeat (2) @(negedge clock);
    uartRxPin = 1'b1;
    repeat (3 * BIT) @(negedge clock);
    check("glitch_cnt", 32'(fifoCount), 0);
    check("glitch_ferr", 32'(frameErr), 0);
    check("glitch_ovr", 32'(overrun), 0);

    // Pop while empty is ignored.
    pop = 1'b1;
    @(negedge clock);
    pop = 1'b0;
    check("empty_pop_cnt", 32'(fifoCount), 0);
    check("empty_pop_ready", 32'(rxReady), 0);

    // Fill, then push 8'h77 in the same cycle as a pop.
    for (int i = 0; i < DEPTH; i++) send_frame(8'(8'h20 + i), 1'b1, 1, 0);
    check("fill_cnt", 32'(fifoCount), DEPTH);
    send_frame(8'h77, 1'b1, 1, 2);
    for (int i = 0; i < DEPTH; i++) pop_check("drain_pop");
    check("drain_cnt", 32'(fifoCount), 0);
    check("drain_ovr", 32'(overrun), 0);

    // Mid-frame reset with a stored byte and a pending frame error.
    send_frame(8'h00, 1'b0, 2, 0);
    repeat (2 * BIT) @(negedge clock);
    send_frame(8'h5A, 1'b1, 1, 0);
    check("prerst_ferr", 32'(frameErr), 1);
    check("prerst_rdata", 32'(rdata), 32'(sb_q[0]));
    uartRxPin = 1'b0;
    repeat (BIT) @(negedge clock);
    uartRxPin = 1'b1;
    repeat (3 * BIT) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_reset_state("midrst");
    sb_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (2 * BIT) @(negedge clock);
    send_frame(8'h81, 1'b1, 1, 0);
    check("postrst_cnt", 32'(fifoCount), 1);
    pop_check("postrst_pop");
    check("postrst_empty", 32'(rxReady), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
